// File: rtl/hdmi_ctrl_pkg.sv
// Shared definitions for the HDMI stream sequencer: state encoding and default timing.
package hdmi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_ALIGN     = 3'd3,
    ST_RUN       = 3'd4,
    ST_DRAIN     = 3'd5,
    ST_FAULT     = 3'd6,
    ST_UNUSED    = 3'd7
  } state_t;

  localparam int unsigned SETTLE_CYCLES_DEF  = 1024;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1048576;
  localparam int unsigned CNT_W_DEF          = 21;

  function automatic logic is_streaming(input state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/hdmi_stream_ctrl_sync_2ff.sv
// 1-bit two-flop synchroniser with asynchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hdmi_stream_ctrl.sv
// Frame-aligned HDMI stream sequencer: lock/settle, frame-boundary start/stop, source select.
// Optional lock timeout into FAULT is enabled by defining HDMI_LOCK_TIMEOUT_EN.
module hdmi_stream_ctrl
  import hdmi_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic       clock_pixel,
  input  logic       reset,
  input  logic       iEnable,
  input  logic       iLocked,
  input  logic       iSrcSel,
  input  logic       iFrameEnd,
  output logic       oHdmiStart,
  output logic       oSrcSel,
  output logic [2:0] oState,
  output logic       oBusy,
  output logic       oError
);

  localparam int unsigned CNT_SPAN = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(CNT_SPAN - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef HDMI_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             err_nxt, src_nxt, lock_s;

  sync_2ff u_lock_sync (
    .clk (clock_pixel),
    .rst (reset),
    .d   (iLocked),
    .q   (lock_s)
  );

  assign cnt_inc = (cnt >= CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign oState  = state;

  // Lock loss is tested first in every active state so it dominates enable and frame events.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = oError;
    src_nxt   = oSrcSel;
    case (state)
      ST_IDLE: begin
        if (iEnable) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      ST_WAIT_LOCK: begin
        if (!iEnable) begin
          state_nxt = ST_IDLE;
        end else if (lock_s) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end
`ifdef HDMI_LOCK_TIMEOUT_EN
        else if (cnt == TIMEOUT_LAST) begin
          state_nxt = ST_FAULT;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
`endif
      end
      ST_SETTLE: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (!iEnable) begin
          state_nxt = ST_IDLE;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = ST_ALIGN;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_ALIGN: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (!iEnable) begin
          state_nxt = ST_IDLE;
        end else if (iFrameEnd) begin
          state_nxt = ST_RUN;
          src_nxt   = iSrcSel;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end else begin
          if (iFrameEnd) src_nxt = iSrcSel;
          if (!iEnable) state_nxt = iFrameEnd ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!lock_s) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end else if (iEnable) begin
          state_nxt = ST_RUN;
          if (iFrameEnd) src_nxt = iSrcSel;
        end else if (iFrameEnd) begin
          state_nxt = ST_IDLE;
        end
      end
`ifdef HDMI_LOCK_TIMEOUT_EN
      ST_FAULT: begin
        err_nxt = 1'b1;
        if (!iEnable) state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_pixel or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      oError     <= 1'b0;
      oSrcSel    <= 1'b0;
      oHdmiStart <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      oError     <= err_nxt;
      oSrcSel    <= src_nxt;
      oHdmiStart <= is_streaming(state_nxt);
      oBusy      <= (state_nxt != ST_IDLE) && (state_nxt != ST_FAULT);
    end
  end

endmodule

// File: tb/tb_hdmi_stream_ctrl.sv
// Scoreboard bench for hdmi_stream_ctrl; timeout checks run when HDMI_LOCK_TIMEOUT_EN is defined.
module tb_hdmi_stream_ctrl;

  logic       clock_pixel = 1'b0;
  logic       reset       = 1'b1;
  logic       iEnable     = 1'b0;
  logic       iLocked     = 1'b0;
  logic       iSrcSel     = 1'b0;
  logic       iFrameEnd   = 1'b0;
  logic       oHdmiStart, oSrcSel, oBusy, oError;
  logic [2:0] oState;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct packed {
    logic [2:0] st;
    logic       start;
    logic       src;
    logic       err;
    logic       busy;
  } snap_t;

  typedef struct {
    string name;
    snap_t v;
    int    at;
  } exp_t;

  exp_t  exp_q[$];
  snap_t prev;

  hdmi_stream_ctrl #(
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (64),
    .CNT_W          (21)
  ) dut (
    .clock_pixel (clock_pixel),
    .reset       (reset),
    .iEnable     (iEnable),
    .iLocked     (iLocked),
    .iSrcSel     (iSrcSel),
    .iFrameEnd   (iFrameEnd),
    .oHdmiStart  (oHdmiStart),
    .oSrcSel     (oSrcSel),
    .oState      (oState),
    .oBusy       (oBusy),
    .oError      (oError)
  );

  always #5 clock_pixel = ~clock_pixel;
  always @(posedge clock_pixel) cyc <= cyc + 1;

  function automatic snap_t cur();
    snap_t s;
    s.st    = oState;
    s.start = oHdmiStart;
    s.src   = oSrcSel;
    s.err   = oError;
    s.busy  = oBusy;
    return s;
  endfunction

  // Any change on the outputs consumes the next predicted snapshot.
  always @(negedge clock_pixel) begin
    snap_t s;
    exp_t  e;
    if (mon_en) begin
      s = cur();
      if (s != prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got st=%0d start=%b src=%b err=%b busy=%b",
                   cyc, s.st, s.start, s.src, s.err, s.busy);
        end else begin
          e = exp_q.pop_front();
          if (s != e.v || (e.at >= 0 && e.at != cyc)) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got st=%0d start=%b src=%b err=%b busy=%b, want cyc=%0d st=%0d start=%b src=%b err=%b busy=%b",
                     e.name, cyc, s.st, s.start, s.src, s.err, s.busy,
                     e.at, e.v.st, e.v.start, e.v.src, e.v.err, e.v.busy);
          end
        end
        prev = s;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_pixel);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [2:0] st, input logic start,
                            input logic src, input logic err, input logic busy, input int at);
    exp_t e;
    e.name    = name;
    e.v.st    = st;
    e.v.start = start;
    e.v.src   = src;
    e.v.err   = err;
    e.v.busy  = busy;
    e.at      = at;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic pulse_fe();
    iFrameEnd = 1'b1;
    tick(1);
    iFrameEnd = 1'b0;
  endtask

  // IDLE -> WAIT_LOCK -> SETTLE (16 cycles) -> ALIGN -> RUN on a frame end; lock_s must already be 1.
  task automatic bring_up(input logic src0, input logic src_run);
    int c;
    c = cyc;
    expect_out("enable_wait_lock", 3'd1, 1'b0, src0, 1'b0, 1'b1, c + 1);
    expect_out("settle_entry",     3'd2, 1'b0, src0, 1'b0, 1'b1, c + 2);
    expect_out("align_entry",      3'd3, 1'b0, src0, 1'b0, 1'b1, c + 18);
    iEnable = 1'b1;
    tick(25);
    iSrcSel = src_run;
    expect_out("run_entry", 3'd4, 1'b1, src_run, 1'b0, 1'b1, cyc + 1);
    pulse_fe();
  endtask

  initial begin
    tick(3);
    check("reset_state", 32'(oState), 32'd0);
    check("reset_start", 32'(oHdmiStart), 32'd0);
    check("reset_src",   32'(oSrcSel), 32'd0);
    check("reset_busy",  32'(oBusy), 32'd0);
    check("reset_err",   32'(oError), 32'd0);
    reset   = 1'b0;
    iLocked = 1'b1;
    prev    = cur();
    mon_en  = 1'b1;
    tick(5);

    // clean bring-up
    bring_up(1'b0, 1'b0);

    // mid-frame source change waits for the frame end
    tick(40);
    iSrcSel = 1'b1;
    tick(59);
    expect_out("src_switch_at_frame_end", 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, cyc + 1);
    pulse_fe();

    // frame-aligned stop
    tick(40);
    expect_out("drain_entry", 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, cyc + 1);
    iEnable = 1'b0;
    tick(59);
    expect_out("drain_to_idle", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, cyc + 1);
    pulse_fe();
    tick(5);

    // lock loss in RUN and recovery
    bring_up(1'b1, 1'b0);
    tick(20);
    expect_out("lockloss_run", 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, cyc + 3);
    iLocked = 1'b0;
    tick(10);
    expect_out("relock_settle", 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, cyc + 3);
    expect_out("relock_align",  3'd3, 1'b0, 1'b0, 1'b1, 1'b1, cyc + 19);
    iLocked = 1'b1;
    tick(25);
    expect_out("relock_run", 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, cyc + 1);
    pulse_fe();

    // drain then re-enable: no gap in the stream
    tick(10);
    expect_out("drain_again", 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, cyc + 1);
    iEnable = 1'b0;
    tick(5);
    expect_out("drain_reenable", 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, cyc + 1);
    iEnable = 1'b1;
    tick(10);

    // disable coincident with the frame end goes straight to IDLE
    expect_out("run_stop_on_frame_end", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, cyc + 1);
    iEnable = 1'b0;
    pulse_fe();
    tick(5);

    // lock loss while draining; re-enable clears the sticky error
    bring_up(1'b0, 1'b0);
    tick(10);
    expect_out("drain_entry2", 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, cyc + 1);
    iEnable = 1'b0;
    tick(5);
    expect_out("lockloss_drain", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, cyc + 3);
    iLocked = 1'b0;
    tick(10);

`ifdef HDMI_LOCK_TIMEOUT_EN
    expect_out("timeout_wait_lock", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, cyc + 1);
    expect_out("timeout_fault",     3'd6, 1'b0, 1'b0, 1'b1, 1'b0, cyc + 65);
    iEnable = 1'b1;
    tick(70);
    expect_out("fault_exit", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, cyc + 1);
    iEnable = 1'b0;
    tick(3);
    expect_out("reenable_clears_err", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, cyc + 1);
    iEnable = 1'b1;
    tick(3);
    expect_out("wait_lock_abort", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, cyc + 1);
    iEnable = 1'b0;
    tick(3);
`endif

    // asynchronous reset in RUN
    iLocked = 1'b1;
    tick(5);
    bring_up(1'b0, 1'b1);
    tick(10);
    expect_out("async_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    @(posedge clock_pixel);
    #2 reset = 1'b1;
    #1;
    check("async_rst_start", 32'(oHdmiStart), 32'd0);
    check("async_rst_src",   32'(oSrcSel), 32'd0);
    check("async_rst_state", 32'(oState), 32'd0);
    check("async_rst_busy",  32'(oBusy), 32'd0);
    iEnable = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(3);
    check("post_reset_state", 32'(oState), 32'd0);
    check("post_reset_start", 32'(oHdmiStart), 32'd0);

    tick(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
